store_m: RTL

STORE_M -- requirements
Module: store_m

---
 rtl/store_m.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/store_m.sv
`default_nettype none
// ============================================================================
// Module   : store_m
// Purpose  : Tile-to-byte store engine. Accepts a store request (base byte
//            address + length in bits), then receives TILE_WIDTH-bit tiles
//            and writes each one to a byte-wide memory, most significant byte
//            first. Writes beyond the requested length are suppressed.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            valid_in        - start request (sampled only when idle)
//            dram_addr       - 24-bit base byte address
//            length          - 20-bit transfer length in bits
//            tile_in/valid   - tile data and its valid strobe
//            tile_ready      - tile accepted this cycle when tile_valid=1
//            mem_we/addr/din - byte write port
//            tile_done       - one-cycle pulse after each tile is written
//            valid_out       - store complete, held until the next start
//            busy            - engine not idle
// Revision : 1.0 - initial release
// ============================================================================
module store_m #(
  parameter int TILE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [23:0]           dram_addr,
  input  logic [19:0]           length,
  input  logic [TILE_WIDTH-1:0] tile_in,
  input  logic                  tile_valid,
  output logic                  tile_ready,
  output logic                  mem_we,
  output logic [23:0]           mem_addr,
  output logic [7:0]            mem_din,
  output logic                  tile_done,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int NUM_BYTES = TILE_WIDTH / 8;
  localparam int BC_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  // Length comparisons are done at 32 bits so sums never overflow.
  localparam int CMP_W     = 32;
  localparam logic [BC_W-1:0] c_last_byte = BC_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TILE = 3'd1,
    ST_WRITING   = 3'd2,
    ST_NEXT_TILE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [23:0]           r_wr_ptr;
  logic [19:0]           r_length;
  logic [19:0]           r_length_cnt;
  logic [BC_W-1:0]       r_byte_cnt;
  logic [TILE_WIDTH-1:0] r_tile_buf;
  logic                  r_valid_out;

  logic [CMP_W-1:0]      w_bit_pos;
  logic                  w_byte_live;
  logic                  w_more_tiles;
  logic [BC_W+2:0]       w_sel_lo;

  // Bit offset of the current byte within the whole transfer.
  assign w_bit_pos    = CMP_W'(r_length_cnt) + (CMP_W'(r_byte_cnt) << 3);
  // A byte is written if any of its bits lie inside the length, so a partial
  // final byte is still written whole.
  assign w_byte_live  = (w_bit_pos < CMP_W'(r_length));
  assign w_more_tiles = ((CMP_W'(r_length_cnt) + CMP_W'(TILE_WIDTH)) < CMP_W'(r_length));
  // Byte k of the buffer, counting from the most significant end.
  assign w_sel_lo     = {c_last_byte - r_byte_cnt, 3'b000};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (valid_in) begin
          w_state_nxt = (length == 20'd0) ? ST_DONE : ST_WAIT_TILE;
        end
      end
      ST_WAIT_TILE: begin
        if (tile_valid) begin
          w_state_nxt = ST_WRITING;
        end
      end
      ST_WRITING: begin
        if (r_byte_cnt == c_last_byte) begin
          w_state_nxt = ST_NEXT_TILE;
        end
      end
      ST_NEXT_TILE: begin
        w_state_nxt = w_more_tiles ? ST_WAIT_TILE : ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_length     <= '0;
      r_length_cnt <= '0;
      r_byte_cnt   <= '0;
      r_tile_buf   <= '0;
      r_valid_out  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (valid_in) begin
            r_wr_ptr     <= dram_addr;
            r_length     <= length;
            r_length_cnt <= '0;
            // A zero-length store completes immediately via DONE.
            r_valid_out  <= (length == 20'd0);
          end
        end
        ST_WAIT_TILE: begin
          if (tile_valid) begin
            r_tile_buf <= tile_in;
            r_byte_cnt <= '0;
          end
        end
        ST_WRITING: begin
          if (w_byte_live) begin
            r_wr_ptr <= r_wr_ptr + 24'd1;
          end
          r_byte_cnt <= r_byte_cnt + BC_W'(1);
        end
        ST_NEXT_TILE: begin
          r_length_cnt <= r_length_cnt + 20'(TILE_WIDTH);
          if (!w_more_tiles) begin
            r_valid_out <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign tile_ready = (r_state == ST_WAIT_TILE);
  assign mem_we     = (r_state == ST_WRITING) && w_byte_live;
  assign mem_addr   = r_wr_ptr;
  assign mem_din    = r_tile_buf[w_sel_lo +: 8];
  assign tile_done  = (r_state == ST_NEXT_TILE);
  assign valid_out  = r_valid_out;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
